jze_branch_predictor_ctrl: RTL and testbench
============================================

Name: jze_branch_predictor_ctrl

Overview:
- Dynamic predictor and sequencer for JZE conditional branches in the MicroEV20 microsequencer.
- Holds a table of 2-bit saturating counters indexed by low PC bits and issues a taken/not-taken prediction at decode.
- Drives the prediction-checker inputs (aux_last_pred, aux_pred_type) and holds them stable until the checker reports.
- On the checker result, trains the table; on a mispredict, issues a one-cycle flush plus redirect.

Parameters:
- IDX_W, 4, index width; table depth = 2^IDX_W entries.
- ADDR_W, 16, microcode/PC address width.
- TIMEOUT, 15, maximum cycles in PENDING before abandoning the prediction (1..255).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- br_valid  in  1  decode presents a branch this cycle.
- br_type  in  2  branch type; 2'b01 = JZE, all other values ignored.
- br_index  in  IDX_W  low PC bits of the branch.
- br_target  in  ADDR_W  taken-path address.
- br_fallthru  in  ADDR_W  not-taken-path address.
- pred_valid  out  1  one-cycle pulse: prediction issued.
- pred_taken  out  1  prediction; qualified by pred_valid.
- aux_last_pred  out  1  latched prediction, to checker.
- aux_pred_type  out  2  2'b01 while PENDING, else 2'b00, to checker.
- checked  in  1  checker evaluated the branch.
- correct_pred  in  1  actual branch direction (1 = taken), valid with checked.
- incorrect_pred  in  1  mispredict flag, valid with checked.
- busy  out  1  prediction outstanding; decode must stall further branches.
- flush  out  1  one-cycle pipeline flush pulse.
- redirect_valid  out  1  one-cycle pulse, coincident with flush.
- redirect_addr  out  ADDR_W  corrected fetch address.
- timeout_err  out  1  one-cycle pulse when a prediction is abandoned.
- miss_count  out  16  mispredict counter, saturating.

Behaviour:
- Reset: all table entries = 2'b01 (weakly not-taken); state = IDLE. Outputs: pred_valid, pred_taken, aux_last_pred, busy, flush, redirect_valid, timeout_err = 0; aux_pred_type = 2'b00; redirect_addr = 0; miss_count = 0. Reset asserted in any state aborts the operation with no table update.
- Prediction rule: prediction = table[br_index][1], read combinationally in IDLE.
- IDLE:
  - Accepting cycle: br_valid=1 and br_type=01.
  - On the accepting cycle, pred_valid=1 and pred_taken=prediction in the same cycle.
  - On the next posedge, latch index, target, fallthru, and prediction (into aux_last_pred); go to PENDING.
  - br_valid with any other type: no action.
  - checked in IDLE: ignored.
- PENDING:
  - busy=1; aux_pred_type=01; aux_last_pred held constant, since the checker samples it on negedge.
  - Timeout counter starts at 0 and increments each cycle.
  - On checked=1, capture outcome = correct_pred. Go to FLUSH if incorrect_pred=1, else to UPDATE.
  - If the counter reaches TIMEOUT with no checked: timeout_err=1 for one cycle, no table update, go to IDLE.
  - checked on the same cycle the counter reaches TIMEOUT: checked wins.
- UPDATE (1 cycle):
  - busy=1; aux_pred_type=00.
  - Entry update: outcome=1 increments, saturating at 11; outcome=0 decrements, saturating at 00.
  - Go to IDLE.
- FLUSH (1 cycle):
  - busy=1; flush=1; redirect_valid=1.
  - redirect_addr = outcome ? latched target : latched fallthru.
  - Same saturating table update as UPDATE.
  - miss_count increments, saturating at 16'hFFFF.
  - Go to IDLE.
- Back-to-back branches: br_valid while busy=1 (PENDING/UPDATE/FLUSH) is ignored and not queued. The first acceptance after a resolution is the cycle after UPDATE/FLUSH.
- redirect_addr holds its last value between flushes.

Test Plan:
- Reset, then JZE at index 3 → pred_valid=1, pred_taken=0, busy=1 next cycle, aux_pred_type=01, aux_last_pred=0.
- Previous case, then checked=1, correct_pred=1, incorrect_pred=1, target=0x0040 → flush=1, redirect_valid=1, redirect_addr=0x0040 one cycle; miss_count=1; entry 3 becomes 10. Next JZE at index 3 predicts taken.
- Three correct taken resolutions at index 5 → entry saturates at 11. A fourth taken resolution leaves 11. One not-taken resolution gives 10 and the prediction stays taken.
- Branch accepted, no checked for 15 cycles → timeout_err pulse, no flush, table unchanged. br_valid during PENDING is ignored: no second pred_valid.
- Assert reset during PENDING → busy=0, aux_pred_type=00, all entries 01, miss_count=0 immediately, without waiting for a clock.
- Force miss_count to 0xFFFF via 65535 mispredicts (or a bench back-door), one more mispredict → miss_count stays 0xFFFF.

Source files
------------

// File: rtl/jze_branch_predictor_ctrl.sv
// JZE branch predictor and sequencer for the MicroEV20 microsequencer.
// A table of 2-bit saturating counters, indexed by low PC bits, predicts
// each JZE at decode. The prediction is held for the checker while it is
// outstanding, and the checker's result then trains the table. A
// mispredict produces a one-cycle flush and a redirect to the correct path.
module jze_branch_predictor_ctrl #(
    parameter int IDX_W   = 4,
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              br_valid,
    input  logic [1:0]        br_type,
    input  logic [IDX_W-1:0]  br_index,
    input  logic [ADDR_W-1:0] br_target,
    input  logic [ADDR_W-1:0] br_fallthru,
    output logic              pred_valid,
    output logic              pred_taken,
    output logic              aux_last_pred,
    output logic [1:0]        aux_pred_type,
    input  logic              checked,
    input  logic              correct_pred,
    input  logic              incorrect_pred,
    output logic              busy,
    output logic              flush,
    output logic              redirect_valid,
    output logic [ADDR_W-1:0] redirect_addr,
    output logic              timeout_err,
    output logic [15:0]       miss_count
);

    localparam int         DEPTH      = 1 << IDX_W;
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PENDING,
        S_UPDATE,
        S_FLUSH
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          ctr_q [DEPTH];
    logic [IDX_W-1:0]    idx_q;
    logic [ADDR_W-1:0]   target_q;
    logic [ADDR_W-1:0]   fallthru_q;
    logic                pred_q;
    logic                outcome_q;
    logic [7:0]          timer_q;
    logic [ADDR_W-1:0]   redirect_addr_q;
    logic [15:0]         miss_count_q;
    logic                accept;
    logic                timeout_hit;

    // Move a counter one step toward the observed direction, clamped at 00/11.
    function automatic logic [1:0] sat_update(input logic [1:0] c, input logic up);
        if (up)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    // Next-state and output decode.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d        = state_q;
        accept         = (state_q == S_IDLE) && br_valid && (br_type == 2'b01);
        timeout_hit    = (state_q == S_PENDING) && !checked && (timer_q == TIMER_LAST);
        pred_valid     = accept;
        pred_taken     = accept & ctr_q[br_index][1];
        busy           = (state_q != S_IDLE);
        aux_pred_type  = (state_q == S_PENDING) ? 2'b01 : 2'b00;
        flush          = (state_q == S_FLUSH);
        redirect_valid = (state_q == S_FLUSH);
        timeout_err    = timeout_hit;

        case (state_q)
            S_IDLE: begin
                if (accept)
                    state_d = S_PENDING;
            end
            S_PENDING: begin
                // A result arriving on the last allowed cycle wins over the timeout.
                if (checked)
                    state_d = incorrect_pred ? S_FLUSH : S_UPDATE;
                else if (timeout_hit)
                    state_d = S_IDLE;
            end
            S_UPDATE: state_d = S_IDLE;
            S_FLUSH:  state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (reset)
            state_q <= S_IDLE;
        else
            state_q <= state_d;
    end

    // Branch context, training table, redirect address and miss counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: the counter table is reset explicitly, so it is built from flops rather than a RAM macro.
            for (int i = 0; i < DEPTH; i++)
                ctr_q[i] <= 2'b01;
            idx_q           <= '0;
            target_q        <= '0;
            fallthru_q      <= '0;
            pred_q          <= 1'b0;
            outcome_q       <= 1'b0;
            timer_q         <= '0;
            redirect_addr_q <= '0;
            miss_count_q    <= '0;
        end else begin
            if (accept) begin
                idx_q      <= br_index;
                target_q   <= br_target;
                fallthru_q <= br_fallthru;
                pred_q     <= ctr_q[br_index][1];
            end

            if (state_q == S_PENDING)
                timer_q <= timer_q + 8'd1;
            else
                timer_q <= '0;

            // The redirect target is resolved on the checker cycle so it is ready during FLUSH.
            if (state_q == S_PENDING && checked) begin
                outcome_q <= correct_pred;
                if (incorrect_pred)
                    redirect_addr_q <= correct_pred ? target_q : fallthru_q;
            end

            if (state_q == S_UPDATE || state_q == S_FLUSH)
                ctr_q[idx_q] <= sat_update(ctr_q[idx_q], outcome_q);

            if (state_q == S_FLUSH && miss_count_q != 16'hFFFF)
                miss_count_q <= miss_count_q + 16'd1;
        end
    end

    assign aux_last_pred = pred_q;
    assign redirect_addr = redirect_addr_q;
    assign miss_count    = miss_count_q;

endmodule

// File: tb/tb_jze_branch_predictor_ctrl.sv
// Self-checking bench for jze_branch_predictor_ctrl: randomized branch
// traffic compared against a counter-table reference model.
module tb_jze_branch_predictor_ctrl;

    localparam int IDX_W   = 4;
    localparam int ADDR_W  = 16;
    localparam int TIMEOUT = 15;
    localparam int DEPTH   = 1 << IDX_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              br_valid;
    logic [1:0]        br_type;
    logic [IDX_W-1:0]  br_index;
    logic [ADDR_W-1:0] br_target;
    logic [ADDR_W-1:0] br_fallthru;
    logic              pred_valid;
    logic              pred_taken;
    logic              aux_last_pred;
    logic [1:0]        aux_pred_type;
    logic              checked;
    logic              correct_pred;
    logic              incorrect_pred;
    logic              busy;
    logic              flush;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_addr;
    logic              timeout_err;
    logic [15:0]       miss_count;

    int n_run  = 0;
    int n_fail = 0;

    // Reference model: per-entry counter strength 0..3, mispredict total, last redirect.
    int          model_ctr [DEPTH];
    int          model_miss;
    logic [15:0] model_redir;

    jze_branch_predictor_ctrl #(
        .IDX_W  (IDX_W),
        .ADDR_W (ADDR_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .br_valid      (br_valid),
        .br_type       (br_type),
        .br_index      (br_index),
        .br_target     (br_target),
        .br_fallthru   (br_fallthru),
        .pred_valid    (pred_valid),
        .pred_taken    (pred_taken),
        .aux_last_pred (aux_last_pred),
        .aux_pred_type (aux_pred_type),
        .checked       (checked),
        .correct_pred  (correct_pred),
        .incorrect_pred(incorrect_pred),
        .busy          (busy),
        .flush         (flush),
        .redirect_valid(redirect_valid),
        .redirect_addr (redirect_addr),
        .timeout_err   (timeout_err),
        .miss_count    (miss_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic bit model_pred(input int i);
        return model_ctr[i] >= 2;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) model_ctr[i] = 1;
        model_miss  = 0;
        model_redir = '0;
    endtask

    task automatic model_train(input int i, input bit taken);
        if (taken && model_ctr[i] < 3) model_ctr[i]++;
        else if (!taken && model_ctr[i] > 0) model_ctr[i]--;
    endtask

    // Full branch transaction. Accepts at the next negedge, waits wait_n
    // PENDING cycles, then resolves (give_check) or lets the timer expire.
    task automatic run_branch(input int idx, input logic [15:0] tgt, input logic [15:0] ft,
                              input int wait_n, input bit give_check, input bit actual);
        bit p;
        bit mis;
        bit resolved;
        bit timed_out;
        p = model_pred(idx);
        mis = (actual != p);
        resolved = 1'b0;
        timed_out = 1'b0;

        @(negedge clk);
        br_valid = 1'b1; br_type = 2'b01; br_index = idx[IDX_W-1:0];
        br_target = tgt; br_fallthru = ft; checked = 1'b0;
        #1;
        n_run++; if (pred_valid !== 1'b1) begin n_fail++; $display("FAIL accept_pred_valid idx=%0d got=%b exp=1", idx, pred_valid); end
        n_run++; if (pred_taken !== p) begin n_fail++; $display("FAIL accept_pred_taken idx=%0d got=%b exp=%b", idx, pred_taken, p); end
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL accept_busy got=%b exp=0", busy); end
        n_run++; if (miss_count !== 16'(model_miss)) begin n_fail++; $display("FAIL miss_count got=%h exp=%h", miss_count, 16'(model_miss)); end
        n_run++; if (redirect_addr !== model_redir) begin n_fail++; $display("FAIL redirect_hold got=%h exp=%h", redirect_addr, model_redir); end

        for (int k = 0; k < TIMEOUT; k++) begin
            @(negedge clk);
            // Traffic while busy must be ignored, and the latched context must not move.
            br_valid = 1'($urandom_range(0, 1)); br_type = 2'b01;
            br_index = IDX_W'($urandom); br_target = 16'($urandom); br_fallthru = 16'($urandom);
            if (give_check && k == wait_n) begin
                checked = 1'b1; correct_pred = actual; incorrect_pred = mis; resolved = 1'b1;
            end else begin
                checked = 1'b0; correct_pred = 1'($urandom); incorrect_pred = 1'($urandom);
            end
            if (!give_check && k == TIMEOUT - 1) timed_out = 1'b1;
            #1;
            n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL pend_busy k=%0d got=%b exp=1", k, busy); end
            n_run++; if (aux_pred_type !== 2'b01) begin n_fail++; $display("FAIL pend_type k=%0d got=%b exp=01", k, aux_pred_type); end
            n_run++; if (aux_last_pred !== p) begin n_fail++; $display("FAIL pend_last_pred k=%0d got=%b exp=%b", k, aux_last_pred, p); end
            n_run++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL pend_no_pred k=%0d got=%b exp=0", k, pred_valid); end
            n_run++; if (timeout_err !== timed_out) begin n_fail++; $display("FAIL pend_timeout k=%0d got=%b exp=%b", k, timeout_err, timed_out); end
            if (resolved || timed_out) break;
        end

        if (resolved) begin
            model_train(idx, actual);
            if (mis) begin
                if (model_miss < 65535) model_miss++;
                model_redir = actual ? tgt : ft;
            end
            @(negedge clk);
            br_valid = 1'($urandom_range(0, 1)); checked = 1'b0;
            #1;
            n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL resolve_busy got=%b exp=1", busy); end
            n_run++; if (aux_pred_type !== 2'b00) begin n_fail++; $display("FAIL resolve_type got=%b exp=00", aux_pred_type); end
            n_run++; if (flush !== mis) begin n_fail++; $display("FAIL resolve_flush got=%b exp=%b", flush, mis); end
            n_run++; if (redirect_valid !== mis) begin n_fail++; $display("FAIL resolve_redirect_valid got=%b exp=%b", redirect_valid, mis); end
            n_run++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL resolve_no_pred got=%b exp=0", pred_valid); end
            n_run++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL resolve_timeout got=%b exp=0", timeout_err); end
            if (mis) begin
                n_run++; if (redirect_addr !== model_redir) begin n_fail++; $display("FAIL redirect_addr got=%h exp=%h", redirect_addr, model_redir); end
            end
        end
    endtask

    // One quiet IDLE cycle confirming the controller settled.
    task automatic idle_check();
        @(negedge clk);
        br_valid = 1'b0; checked = 1'b0;
        #1;
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy got=%b exp=0", busy); end
        n_run++; if (flush !== 1'b0) begin n_fail++; $display("FAIL idle_flush got=%b exp=0", flush); end
        n_run++; if (timeout_err !== 1'b0) begin n_fail++; $display("FAIL idle_timeout got=%b exp=0", timeout_err); end
        n_run++; if (aux_pred_type !== 2'b00) begin n_fail++; $display("FAIL idle_type got=%b exp=00", aux_pred_type); end
        n_run++; if (miss_count !== 16'(model_miss)) begin n_fail++; $display("FAIL idle_miss_count got=%h exp=%h", miss_count, 16'(model_miss)); end
        n_run++; if (redirect_addr !== model_redir) begin n_fail++; $display("FAIL idle_redirect got=%h exp=%h", redirect_addr, model_redir); end
    endtask

    task automatic test_reset();
        reset = 1'b1; br_valid = 1'b0; br_type = 2'b00; br_index = '0;
        br_target = '0; br_fallthru = '0; checked = 1'b0; correct_pred = 1'b0; incorrect_pred = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        #1;
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_run++; if (pred_valid !== 1'b0 || pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred got=%b%b exp=00", pred_valid, pred_taken); end
        n_run++; if (aux_last_pred !== 1'b0 || aux_pred_type !== 2'b00) begin n_fail++; $display("FAIL reset_aux got=%b/%b exp=0/00", aux_last_pred, aux_pred_type); end
        n_run++; if (flush !== 1'b0 || redirect_valid !== 1'b0 || timeout_err !== 1'b0) begin n_fail++; $display("FAIL reset_pulses got=%b%b%b exp=000", flush, redirect_valid, timeout_err); end
        n_run++; if (redirect_addr !== 16'h0 || miss_count !== 16'h0) begin n_fail++; $display("FAIL reset_regs got=%h/%h exp=0/0", redirect_addr, miss_count); end
        @(negedge clk);
        reset = 1'b0;
        // A non-JZE branch type must not be accepted.
        @(negedge clk);
        br_valid = 1'b1; br_type = 2'b10; br_index = 4'd3;
        #1;
        n_run++; if (pred_valid !== 1'b0) begin n_fail++; $display("FAIL nonjze_pred_valid got=%b exp=0", pred_valid); end
        idle_check();
    endtask

    task automatic test_first_mispredict();
        // Weak not-taken predicts 0; actual taken is a mispredict to 0x0040.
        run_branch(3, 16'h0040, 16'h0011, 0, 1'b1, 1'b1);
        // Entry 3 is now weakly taken: this accept must predict taken.
        run_branch(3, 16'h0123, 16'h0456, 2, 1'b1, 1'b1);
        idle_check();
    endtask

    task automatic test_saturation();
        for (int n = 0; n < 4; n++)
            run_branch(5, 16'h0500 + 16'(n), 16'h0600, n, 1'b1, 1'b1);
        run_branch(5, 16'h0700, 16'h0800, 1, 1'b1, 1'b0);
        run_branch(5, 16'h0900, 16'h0A00, 0, 1'b1, 1'b1);
        idle_check();
    endtask

    task automatic test_timeout();
        run_branch(7, 16'h1234, 16'h5678, 0, 1'b0, 1'b0);
        run_branch(7, 16'h1111, 16'h2222, 0, 1'b0, 1'b0);
        // Checker reporting on the final allowed cycle beats the timeout.
        run_branch(7, 16'h3333, 16'h4444, TIMEOUT - 1, 1'b1, 1'b1);
        idle_check();
    endtask

    task automatic test_back_to_back();
        // Each transaction accepts on the cycle right after the previous resolution.
        for (int n = 0; n < 40; n++)
            run_branch(int'($urandom_range(0, 3)), 16'($urandom), 16'($urandom),
                       int'($urandom_range(0, TIMEOUT - 1)), $urandom_range(0, 7) != 0,
                       1'($urandom));
        idle_check();
    endtask

    task automatic test_miss_saturate();
        @(negedge clk);
        force dut.miss_count_q = 16'hFFFE;
        @(negedge clk);
        release dut.miss_count_q;
        model_miss = 65534;
        for (int n = 0; n < 3; n++)
            run_branch(9, 16'h0900, 16'h0901, 0, 1'b1, !model_pred(9));
        idle_check();
    endtask

    task automatic test_reset_midflight();
        // Entry 5 predicts taken, so a held aux_last_pred of 1 must drop on reset.
        @(negedge clk);
        br_valid = 1'b1; br_type = 2'b01; br_index = 4'd5; br_target = 16'hAAAA; br_fallthru = 16'hBBBB;
        @(negedge clk);
        br_valid = 1'b0;
        #1;
        n_run++; if (aux_last_pred !== 1'(model_pred(5)) || busy !== 1'b1) begin n_fail++; $display("FAIL midflight_pending got=%b/%b exp=%b/1", aux_last_pred, busy, model_pred(5)); end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_reset_busy got=%b exp=0", busy); end
        n_run++; if (aux_pred_type !== 2'b00) begin n_fail++; $display("FAIL async_reset_type got=%b exp=00", aux_pred_type); end
        n_run++; if (miss_count !== 16'h0) begin n_fail++; $display("FAIL async_reset_miss got=%h exp=0", miss_count); end
        n_run++; if (aux_last_pred !== 1'b0 || redirect_addr !== 16'h0) begin n_fail++; $display("FAIL async_reset_regs got=%b/%h exp=0/0", aux_last_pred, redirect_addr); end
        @(negedge clk);
        reset = 1'b0;
        // Every entry must be back to weakly not-taken.
        for (int i = 0; i < DEPTH; i++)
            run_branch(i, 16'(i * 16), 16'(i * 16 + 1), 0, 1'b1, 1'($urandom));
        idle_check();
    endtask

    initial begin
        test_reset();
        test_first_mispredict();
        test_saturation();
        test_timeout();
        test_back_to_back();
        test_miss_saturate();
        test_reset_midflight();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
